logic_unit_arbiter: RTL

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_arbiter_if.sv | 32 +++
 rtl/logic_unit_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter_if.sv
`default_nettype none
// ============================================================================
// logic_unit_arbiter_if : request/response bundle for logic_unit_arbiter
// Rev 1.0 - initial release
// ============================================================================
interface logic_unit_arbiter_if #(
   parameter int BITS = 4,
   parameter int REQS = 4
);
   logic [REQS-1:0]      req_valid_i;
   logic [2*REQS-1:0]    req_op_i;
   logic [BITS*REQS-1:0] req_a_i;
   logic [BITS*REQS-1:0] req_b_i;
   logic [REQS-1:0]      req_ready_o;
   logic                 resp_valid_o;
   logic [BITS-1:0]      resp_data_o;
   logic [2:0]           resp_id_o;
   logic                 resp_ready_i;

   // Requesters and result consumer
   modport master (
      output req_valid_i, req_op_i, req_a_i, req_b_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, resp_data_o, resp_id_o
   );

   // Arbiter side
   modport slave (
      input  req_valid_i, req_op_i, req_a_i, req_b_i, resp_ready_i,
      output req_ready_o, resp_valid_o, resp_data_o, resp_id_o
   );
endinterface
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// logic_unit_arbiter : round-robin arbiter feeding a shared bitwise logic unit
// Rev 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
   parameter int BITS = 4,
   parameter int REQS = 4
) (
   input  wire logic           clk_i,
   input  wire logic           rst_ni,
   logic_unit_arbiter_if.slave bus
);
   localparam int c_PW = $clog2(REQS);

   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_HOLD = 1'b1;

   logic [0:0]      r_state;
   logic [0:0]      w_state_nxt;
   logic [c_PW-1:0] r_ptr;
   logic [BITS-1:0] r_data;
   logic [2:0]      r_id;

   logic            w_found;
   logic            w_grant;
   logic            w_grant_en;
   logic [c_PW-1:0] w_gnt_idx;
   logic [1:0]      w_op;
   logic [BITS-1:0] w_a;
   logic [BITS-1:0] w_b;
   logic [BITS-1:0] w_result;

   function automatic logic [c_PW-1:0] f_wrap(input logic [c_PW-1:0] p, input int i);
      int s;
      s = int'(p) + i;
      if (s >= REQS) s = s - REQS;
      return c_PW'(s);
   endfunction

   // Grants are blocked during reset so req_ready_o is zero independent of clk_i
   assign w_grant_en = rst_ni && ((r_state == c_IDLE) || bus.resp_ready_i);

   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = '0;
      for (int i = 0; i < REQS; i++) begin
         if (!w_found && bus.req_valid_i[f_wrap(r_ptr, i)]) begin
            w_found   = 1'b1;
            w_gnt_idx = f_wrap(r_ptr, i);
         end
      end
   end

   assign w_grant = w_found && w_grant_en;

   assign w_op = bus.req_op_i[2*w_gnt_idx +: 2];
   assign w_a  = bus.req_a_i[BITS*w_gnt_idx +: BITS];
   assign w_b  = bus.req_b_i[BITS*w_gnt_idx +: BITS];

   always_comb begin
      w_result = '0;
      case (w_op)
         2'b00:   w_result = w_a & w_b;
         2'b01:   w_result = w_a | w_b;
         2'b10:   w_result = w_a ^ w_b;
         default: w_result = ~(w_a | w_b);
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= c_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_grant) w_state_nxt = c_HOLD;
         c_HOLD:  if (bus.resp_ready_i && !w_grant) w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.req_ready_o  = '0;
      bus.resp_valid_o = (r_state == c_HOLD);
      bus.resp_data_o  = r_data;
      bus.resp_id_o    = r_id;
      if (w_grant) bus.req_ready_o = REQS'(1) << w_gnt_idx;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr  <= '0;
         r_data <= '0;
         r_id   <= '0;
      end else if (w_grant) begin
         r_ptr  <= (w_gnt_idx == c_PW'(REQS-1)) ? '0 : w_gnt_idx + 1'b1;
         r_data <= w_result;
         r_id   <= 3'(w_gnt_idx);
      end
   end
endmodule
`default_nettype wire
